// File: rtl/pixel_write_sink.sv
// Pixel write sink: accepts (x, y, colour) plot requests, drops off-screen ones,
// queues the rest in a small FIFO and drains them to the framebuffer port as
// linear-address writes (addr = y*160 + x), in acceptance order.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   in_x/in_y/in_c       pixel coordinates and colour
//   in_plot / in_ready   write request / FIFO not full (combinational)
//   fb_addr/fb_wdata     registered framebuffer address / write data
//   fb_we / fb_ready     write strobe / arbiter grant (write completes on we && ready)
//   fb_rdata             framebuffer read data, 1-cycle latency (FB_XOR_EN only)
//   busy                 FIFO non-empty or write outstanding (combinational)
//   drop_count           saturating count of rejected off-screen writes
//
// Build option: define FB_XOR_EN to make every pixel a read-modify-write that
// XORs the colour onto the existing framebuffer contents.
module pixel_write_sink #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SCREEN_W   = 160,
    parameter int unsigned SCREEN_H   = 120
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  in_x,
    input  logic [6:0]  in_y,
    input  logic [2:0]  in_c,
    input  logic        in_plot,
    output logic        in_ready,
    output logic [14:0] fb_addr,
    output logic [2:0]  fb_wdata,
    output logic        fb_we,
    input  logic        fb_ready,
    input  logic [2:0]  fb_rdata,
    output logic        busy,
    output logic [7:0]  drop_count
);

    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned COL_W  = 3;
    localparam int unsigned CNT_W  = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [COL_W-1:0]  c;
    } pix_t;

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WAIT, ST_WRITE} state_t;

    pix_t              mem_q [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    state_t            state_q;
    logic [ADDR_W-1:0] fb_addr_q;
    logic [COL_W-1:0]  fb_wdata_q;
    logic              fb_we_q;

    logic empty_c, full_c, in_range_c, push_c, drop_c, pop_c;
    pix_t in_pix_c, head_c;

    // FIFO status: extra pointer bit distinguishes full from empty
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign in_range_c = (32'(in_x) < SCREEN_W) && (32'(in_y) < SCREEN_H);
    assign push_c     = in_plot && in_ready && in_range_c;
    assign drop_c     = in_plot && in_ready && !in_range_c;

    // y*160 + x computed at push time so the drain side only moves data
    assign in_pix_c.addr = ADDR_W'({in_y, 7'b0}) + ADDR_W'({in_y, 5'b0}) + ADDR_W'(in_x);
    assign in_pix_c.c    = in_c;
    assign head_c        = mem_q[rd_ptr_q[AW-1:0]];

    // The head is consumed when idle, or when the current write completes
    assign pop_c = !empty_c && ((state_q == ST_IDLE) || ((state_q == ST_WRITE) && fb_ready));

    // Pointer and drop-counter next state
    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push_c);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop_c);
        drop_d   = drop_q;
        if (drop_c && (drop_q != {CNT_W{1'b1}})) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            drop_q   <= drop_d;
        end
    end

    // FIFO storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_pix_c;
        end
    end

`ifdef FB_XOR_EN
    logic [COL_W-1:0] c_q;

    // Read-modify-write drain: READ presents the address, WAIT lets the
    // read data arrive, WRITE holds the XORed pixel until granted
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            fb_addr_q  <= '0;
            fb_wdata_q <= '0;
            fb_we_q    <= 1'b0;
            c_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty_c) begin
                        fb_addr_q <= head_c.addr;
                        c_q       <= head_c.c;
                        state_q   <= ST_READ;
                    end
                end
                ST_READ: state_q <= ST_WAIT;
                ST_WAIT: begin
                    fb_wdata_q <= c_q ^ fb_rdata;
                    fb_we_q    <= 1'b1;
                    state_q    <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (fb_ready) begin
                        fb_we_q <= 1'b0;
                        if (!empty_c) begin
                            fb_addr_q <= head_c.addr;
                            c_q       <= head_c.c;
                            state_q   <= ST_READ;
                        end else begin
                            state_q   <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
`else
    logic unused_rdata;
    assign unused_rdata = ^fb_rdata;

    // Plain drain: one pixel per granted cycle, outputs held while not granted
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            fb_addr_q  <= '0;
            fb_wdata_q <= '0;
            fb_we_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty_c) begin
                        fb_addr_q  <= head_c.addr;
                        fb_wdata_q <= head_c.c;
                        fb_we_q    <= 1'b1;
                        state_q    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (fb_ready) begin
                        if (!empty_c) begin
                            fb_addr_q  <= head_c.addr;
                            fb_wdata_q <= head_c.c;
                        end else begin
                            fb_we_q    <= 1'b0;
                            state_q    <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
`endif

    assign in_ready   = !full_c;
    assign busy       = !empty_c || fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_wdata   = fb_wdata_q;
    assign fb_we      = fb_we_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_pixel_write_sink.sv
// Self-checking bench for pixel_write_sink: directed scenarios plus a random
// phase, all checked against a transaction-level model (queue of accepted
// pixels, saturating drop counter, framebuffer contents array).
module tb_pixel_write_sink;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  in_x;
    logic [6:0]  in_y;
    logic [2:0]  in_c;
    logic        in_plot;
    logic        in_ready;
    logic [14:0] fb_addr;
    logic [2:0]  fb_wdata;
    logic        fb_we;
    logic        fb_ready;
    logic [2:0]  fb_rdata;
    logic        busy;
    logic [7:0]  drop_count;

    always #5 clk = ~clk;

    pixel_write_sink #(.FIFO_DEPTH(DEPTH), .SCREEN_W(160), .SCREEN_H(120)) dut (
        .clk(clk), .resetn(resetn),
        .in_x(in_x), .in_y(in_y), .in_c(in_c), .in_plot(in_plot), .in_ready(in_ready),
        .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_we(fb_we), .fb_ready(fb_ready),
        .fb_rdata(fb_rdata), .busy(busy), .drop_count(drop_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned addr;
        logic [2:0]  c;
    } pix_t;

    pix_t        expq[$];
    int unsigned m_drop = 0;
    int unsigned writes_seen = 0;
    logic [2:0]  fbmem [32768];
    bit          prev_hold = 1'b0;
    logic [14:0] prev_addr;
    logic [2:0]  prev_data;

    initial for (int i = 0; i < 32768; i++) fbmem[i] = 3'd0;

    // Framebuffer read port with one cycle of latency
    always @(posedge clk) fb_rdata <= fbmem[fb_addr];

    // Monitor samples mid-cycle; inputs change just after posedge, so what is
    // seen here is exactly what the next posedge will act on.
    always @(negedge clk) begin
        if (!resetn) begin
            expq.delete();
            m_drop    = 0;
            prev_hold = 1'b0;
        end else begin
            chk("drop_count", drop_count, m_drop);
`ifndef FB_XOR_EN
            chk("busy", busy, expq.size() != 0);
            chk("in_ready", in_ready, (expq.size() - (fb_we ? 1 : 0)) < DEPTH);
`endif
            if (prev_hold) begin
                chk("hold_we", fb_we, 1);
                chk("hold_addr", fb_addr, prev_addr);
                chk("hold_data", fb_wdata, prev_data);
            end
            if (fb_we && fb_ready) begin
                chk("queued_on_we", expq.size() != 0, 1);
                if (expq.size() != 0) begin
                    pix_t e;
                    logic [2:0] exp_d;
                    e = expq.pop_front();
`ifdef FB_XOR_EN
                    exp_d = e.c ^ fbmem[e.addr];
`else
                    exp_d = e.c;
`endif
                    chk("wr_addr", fb_addr, e.addr);
                    chk("wr_data", fb_wdata, exp_d);
                    fbmem[e.addr] = exp_d;
                    writes_seen++;
                end
            end
            prev_hold = fb_we && !fb_ready;
            prev_addr = fb_addr;
            prev_data = fb_wdata;
            if (in_plot && in_ready) begin
                if (in_x < 160 && in_y < 120) begin
                    pix_t p;
                    p.addr = in_y * 160 + in_x;
                    p.c    = in_c;
                    expq.push_back(p);
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int x, input int y, input int c);
        bit ok = 1'b0;
        in_x = 8'(x); in_y = 7'(y); in_c = 3'(c); in_plot = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        chk("push_accept", ok, 1);
        @(posedge clk); #1;
        in_plot = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (expq.size() == 0 && !fb_we) begin ok = 1'b1; break; end
        end
        chk("drain_done", ok, 1);
        @(posedge clk); #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        resetn = 1'b0; in_x = '0; in_y = '0; in_c = '0; in_plot = 1'b0; fb_ready = 1'b0;

        // Reset
        cyc(2);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_fb_we", fb_we, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Single write and latency (read-modify-write variant XORs onto 3'b101)
        fbmem[14452] = 3'b101;
        fb_ready = 1'b1;
        in_x = 8'd52; in_y = 7'd90; in_c = 3'b100; in_plot = 1'b1;
        @(posedge clk); #1;
        in_plot = 1'b0;
        @(negedge clk);
        chk("lat_k1_we", fb_we, 0);
        @(negedge clk);
`ifdef FB_XOR_EN
        chk("xor_read_addr", fb_addr, 14452);
        chk("xor_read_we", fb_we, 0);
        @(negedge clk);
        chk("xor_wait_we", fb_we, 0);
        @(negedge clk);
        chk("single_wdata", fb_wdata, 3'b001);
`else
        chk("single_wdata", fb_wdata, 3'b100);
`endif
        chk("single_we", fb_we, 1);
        chk("single_addr", fb_addr, 14452);
        @(negedge clk);
        chk("single_strobe_end", fb_we, 0);
        @(posedge clk); #1;

        // Backpressure: one pixel parked at the port plus a full FIFO
        fb_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(i, 0, i + 1);
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_addr", fb_addr, 0);
        chk("bp_we", fb_we, 1);
        @(posedge clk); #1;
        fork
            push(5, 0, 6);
            begin cyc(3); fb_ready = 1'b1; end
        join
        drain();

        // Off-screen writes are counted, never written
        push(160, 0, 1);
        push(0, 120, 2);
        cyc(2);
        chk("oor_drop2", drop_count, 2);
        chk("oor_no_we", fb_we, 0);
        in_plot = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_x = 8'(160 + $urandom_range(0, 95));
            in_y = 7'($urandom_range(0, 127));
            in_c = 3'($urandom);
            cyc(1);
        end
        in_plot = 1'b0;
        cyc(2);
        chk("oor_sat", drop_count, 255);
        chk("oor_sat_no_we", fb_we, 0);

        // Reset while writes are queued
        fb_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(10 + i, 7, 5);
        resetn = 1'b0;
        cyc(1);
        resetn = 1'b1;
        fb_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_we", fb_we, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_drop", drop_count, 0);
        cyc(20);

        // Random traffic with random grant
        for (int i = 0; i < 600; i++) begin
            in_plot  = ($urandom_range(0, 2) != 0);
            in_x     = 8'($urandom_range(0, 175));
            in_y     = 7'($urandom_range(0, 127));
            in_c     = 3'($urandom);
            fb_ready = ($urandom_range(0, 3) != 0);
            cyc(1);
        end
        in_plot  = 1'b0;
        fb_ready = 1'b1;
        drain();
        chk("rand_some_writes", writes_seen > 20, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
